fish_req_ctrl: RTL and testbench

- Host-side initiator for the Twofish `datapath` core: accepts 128-bit encrypt/decrypt/round-trip requests on a valid/ready port and sequences the core's Reset/Start/EnDe/busy protocol.
- Holds block and key stable for the whole operation, captures `o`, and returns the result on a valid/ready response port.
- Round-trip mode encrypts, then decrypts the ciphertext with the same key, and flags whether the plaintext came back.
- Sits between the bus/host shim and one `datapath` instance.

---
 rtl/fish_req_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_fish_req_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fish_req_ctrl.sv
// Host-side request sequencer for one Twofish datapath core: runs encrypt,
// decrypt or encrypt-then-decrypt round trips and returns the result.
module fish_req_ctrl #(
    parameter int TIMEOUT   = 64,
    parameter int BUSY_WAIT = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [127:0] req_block_i,
    input  logic [127:0] req_key_i,
    input  logic [1:0]   req_mode_i,
    output logic         resp_valid_o,
    input  logic         resp_ready_i,
    output logic [127:0] resp_data_o,
    output logic         resp_match_o,
    output logic         resp_err_o,
    output logic         core_reset_o,
    output logic         core_start_o,
    output logic         core_ende_o,
    output logic [127:0] core_block_o,
    output logic [127:0] core_key_o,
    input  logic [127:0] core_o_i,
    input  logic         core_busy_i
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CRST, S_CSTART, S_WAIT_HI, S_WAIT_LO, S_CAPT, S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   ct_q, ct_d;
    logic [1:0]     mode_q, mode_d;
    logic           pass2_q, pass2_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   rdata_q, rdata_d;
    logic           rmatch_q, rmatch_d;
    logic           rerr_q, rerr_d;
    logic [CW-1:0]  cnt_inc_s;
    logic           core_active_s;

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            blk_q    <= 128'd0;
            key_q    <= 128'd0;
            ct_q     <= 128'd0;
            mode_q   <= 2'd0;
            pass2_q  <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            rdata_q  <= 128'd0;
            rmatch_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            key_q    <= key_d;
            ct_q     <= ct_d;
            mode_q   <= mode_d;
            pass2_q  <= pass2_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rmatch_q <= rmatch_d;
            rerr_q   <= rerr_d;
        end
    end

    // cnt_q holds the number of cycles elapsed since the start pulse.
    always_comb begin
        if (cnt_q != {CW{1'b1}}) begin
            cnt_inc_s = cnt_q + CW'(1);
        end else begin
            cnt_inc_s = cnt_q;
        end
    end

    // Next-state logic for the request sequencer.
    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        key_d    = key_q;
        ct_d     = ct_q;
        mode_d   = mode_q;
        pass2_d  = pass2_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rmatch_d = rmatch_q;
        rerr_d   = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    blk_d    = req_block_i;
                    key_d    = req_key_i;
                    mode_d   = req_mode_i;
                    ct_d     = 128'd0;
                    pass2_d  = 1'b0;
                    rdata_d  = 128'd0;
                    rmatch_d = 1'b0;
                    if (req_mode_i == 2'd3) begin
                        rerr_d  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        rerr_d  = 1'b0;
                        state_d = S_CRST;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CRST: begin
                state_d = S_CSTART;
            end
            S_CSTART: begin
                cnt_d = CW'(1);
                if (core_busy_i) begin
                    state_d = S_WAIT_LO;
                end else begin
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                cnt_d = cnt_inc_s;
                if (core_busy_i) begin
                    state_d = S_WAIT_LO;
                end else if (cnt_q >= CW'(BUSY_WAIT - 1)) begin
                    rdata_d  = 128'd0;
                    rmatch_d = 1'b0;
                    rerr_d   = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_LO: begin
                cnt_d = cnt_inc_s;
                if (!core_busy_i) begin
                    state_d = S_CAPT;
                end else if (cnt_q >= CW'(TIMEOUT)) begin
                    rdata_d  = 128'd0;
                    rmatch_d = 1'b0;
                    rerr_d   = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            S_CAPT: begin
                if ((mode_q == 2'd2) && !pass2_q) begin
                    ct_d    = core_o_i;
                    pass2_d = 1'b1;
                    state_d = S_CRST;
                end else if (mode_q == 2'd2) begin
                    rdata_d  = ct_q;
                    rmatch_d = (core_o_i == blk_q);
                    state_d  = S_RESP;
                end else begin
                    rdata_d  = core_o_i;
                    rmatch_d = 1'b0;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    rdata_d  = 128'd0;
                    rmatch_d = 1'b0;
                    rerr_d   = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Port decode; core inputs are only driven while a pass is in flight.
    always_comb begin
        core_active_s = (state_q == S_CRST) || (state_q == S_CSTART) ||
                        (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO) ||
                        (state_q == S_CAPT);
        req_ready_o   = (state_q == S_IDLE);
        resp_valid_o  = (state_q == S_RESP);
        resp_data_o   = rdata_q;
        resp_match_o  = rmatch_q;
        resp_err_o    = rerr_q;
        core_reset_o  = rst_i || (state_q == S_CRST);
        core_start_o  = (state_q == S_CSTART);
        if (core_active_s) begin
            core_block_o = pass2_q ? ct_q : blk_q;
            core_key_o   = key_q;
            core_ende_o  = pass2_q || (mode_q == 2'd1);
        end else begin
            core_block_o = 128'd0;
            core_key_o   = 128'd0;
            core_ende_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_fish_req_ctrl.sv
// Bench for fish_req_ctrl: a behavioural core stub plus directed and random
// requests checked against expected results and cycle timing.
module tb_fish_req_ctrl;

    localparam int TIMEOUT   = 64;
    localparam int BUSY_WAIT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [127:0] req_block = 128'd0;
    logic [127:0] req_key = 128'd0;
    logic [1:0]   req_mode = 2'd0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [127:0] resp_data;
    logic         resp_match;
    logic         resp_err;
    logic         core_reset;
    logic         core_start;
    logic         core_ende;
    logic [127:0] core_block;
    logic [127:0] core_key;
    logic [127:0] core_o;
    logic         core_busy;

    int total = 0;
    int bad = 0;
    int n_rst, n_start, first_rst, first_start, t_valid;
    logic [127:0] blk3, key3, blk27;
    logic         ende3, ende27;

    // stub_beh: 0 busy for 20 cycles, 1 busy never rises, 2 busy stuck high
    // stub_fn : 0 o=block^key, 1 toy cipher, 2 toy cipher with corrupt decrypt
    int           stub_beh = 0;
    int           stub_fn = 0;
    int           stub_rem;

    fish_req_ctrl #(.TIMEOUT(TIMEOUT), .BUSY_WAIT(BUSY_WAIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_block_i(req_block), .req_key_i(req_key), .req_mode_i(req_mode),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_match_o(resp_match), .resp_err_o(resp_err),
        .core_reset_o(core_reset), .core_start_o(core_start), .core_ende_o(core_ende),
        .core_block_o(core_block), .core_key_o(core_key),
        .core_o_i(core_o), .core_busy_i(core_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] enc(input logic [127:0] b, input logic [127:0] k);
        logic [127:0] x;
        x = b ^ k;
        return {x[114:0], x[127:115]} + k;
    endfunction

    function automatic logic [127:0] dec(input logic [127:0] c, input logic [127:0] k);
        logic [127:0] x;
        x = c - k;
        x = {x[12:0], x[127:13]};
        return x ^ k;
    endfunction

    function automatic logic [127:0] stub_out(input logic [127:0] b, input logic [127:0] k,
                                              input logic e, input int fn);
        if (fn == 0) return b ^ k;
        if (!e) return enc(b, k);
        if (fn == 2) return dec(b, k) ^ 128'd1;
        return dec(b, k);
    endfunction

    // Behavioural datapath stub.
    always @(posedge clk) begin
        if (core_reset) begin
            core_busy <= 1'b0;
            stub_rem  <= 0;
            core_o    <= 128'd0;
        end else if (core_start) begin
            core_o <= stub_out(core_block, core_key, core_ende, stub_fn);
            if (stub_beh == 1) begin
                core_busy <= 1'b0;
            end else begin
                core_busy <= 1'b1;
                stub_rem  <= 19;
            end
        end else if (core_busy && stub_beh != 2) begin
            if (stub_rem == 0) core_busy <= 1'b0;
            else stub_rem <= stub_rem - 1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request and watches the DUT until resp_valid (cycle N = accept).
    task automatic do_req(input logic [127:0] b, input logic [127:0] k, input logic [1:0] m);
        int rel;
        bit done;
        n_rst = 0; n_start = 0; first_rst = -1; first_start = -1; t_valid = -1;
        @(negedge clk);
        req_block = b; req_key = k; req_mode = m; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_block = ~b; req_key = ~k; req_mode = m ^ 2'd1;
        rel = 1;
        done = 1'b0;
        while (!done && rel <= 200) begin
            @(negedge clk);
            if (core_reset) begin
                n_rst++;
                if (first_rst < 0) first_rst = rel;
            end
            if (core_start) begin
                n_start++;
                if (first_start < 0) first_start = rel;
            end
            if (rel == 3) begin blk3 = core_block; key3 = core_key; ende3 = core_ende; end
            if (rel == 27) begin blk27 = core_block; ende27 = core_ende; end
            if (resp_valid) done = 1'b1;
            else rel++;
        end
        if (done) t_valid = rel;
    endtask

    task automatic ack_resp(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 128'(resp_valid), 128'd0);
        check({tag, "_ready_back"}, 128'(req_ready), 128'd1);
    endtask

    initial begin
        logic [127:0] b, k, held;
        int unstable;
        int stray;

        // reset behaviour
        repeat (2) @(negedge clk);
        check("rst_core_reset", 128'(core_reset), 128'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 128'(req_ready), 128'd1);
        check("rst_ctrl", {resp_valid, resp_match, resp_err, core_start, core_ende, core_reset},
              128'd0);
        check("rst_resp_data", resp_data, 128'd0);
        check("rst_core_block", core_block, 128'd0);
        check("rst_core_key", core_key, 128'd0);

        // mode 0, xor stub
        stub_beh = 0; stub_fn = 0;
        b = {2{64'h0123_4567_89AB_CDEF}};
        k = {128{1'b1}};
        do_req(b, k, 2'd0);
        check("enc_data", resp_data, b ^ k);
        check("enc_flags", {resp_err, resp_match}, 128'd0);
        check("enc_t_valid", 128'(t_valid), 128'd25);
        check("enc_first_rst", 128'(first_rst), 128'd1);
        check("enc_first_start", 128'(first_start), 128'd2);
        check("enc_pulses", 128'({n_rst, n_start}), 128'({32'd1, 32'd1}));
        check("enc_core_in", {blk3 ^ key3, 127'd0, ende3}, {b ^ k, 127'd0, 1'b0});
        ack_resp("enc");

        // mode 2, xor stub with zero key
        b = {4{32'hDEAD_BEEF}};
        do_req(b, 128'd0, 2'd2);
        check("rt_data", resp_data, b);
        check("rt_match", 128'(resp_match), 128'd1);
        check("rt_err", 128'(resp_err), 128'd0);
        check("rt_pulses", 128'({n_rst, n_start}), 128'({32'd2, 32'd2}));
        check("rt_t_valid", 128'(t_valid), 128'd49);
        check("rt_pass2_ende", 128'(ende27), 128'd1);
        ack_resp("rt");

        // busy never rises, mode 1
        stub_beh = 1;
        do_req({4{32'h1234_5678}}, {4{32'h9ABC_DEF0}}, 2'd1);
        check("bw_t_valid", 128'(t_valid - first_start), 128'(BUSY_WAIT));
        check("bw_err", 128'(resp_err), 128'd1);
        check("bw_data", resp_data, 128'd0);
        check("bw_match", 128'(resp_match), 128'd0);
        ack_resp("bw");

        // busy stuck high
        stub_beh = 2;
        do_req({4{32'hCAFE_F00D}}, {4{32'h0BAD_0BAD}}, 2'd0);
        check("to_t_valid", 128'(t_valid - first_start), 128'(TIMEOUT + 1));
        check("to_err", 128'(resp_err), 128'd1);
        check("to_data", resp_data, 128'd0);
        ack_resp("to");

        // reserved mode
        stub_beh = 0;
        do_req({4{32'h5555_AAAA}}, 128'd7, 2'd3);
        check("m3_t_valid", 128'(t_valid), 128'd1);
        check("m3_err", 128'(resp_err), 128'd1);
        check("m3_no_core", 128'({n_rst, n_start}), 128'd0);
        check("m3_data", resp_data, 128'd0);
        ack_resp("m3");

        // response back-pressure for 10 cycles
        b = {4{32'h0F1E_2D3C}};
        k = {4{32'h4B5A_6978}};
        do_req(b, k, 2'd0);
        held = resp_data;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!resp_valid || resp_data !== held || req_ready) unstable++;
        end
        check("hold_stable", 128'(unstable), 128'd0);
        check("hold_data", held, b ^ k);
        ack_resp("hold");

        // random round trips with the toy cipher
        stub_fn = 1;
        for (int i = 0; i < 100; i++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            do_req(b, k, 2'd2);
            check("rnd_rt_data", resp_data, enc(b, k));
            check("rnd_rt_match_err", {resp_match, resp_err}, 128'd2);
            check("rnd_rt_pass2_blk", blk27, enc(b, k));
            ack_resp("rnd_rt");
        end

        // random single-direction requests
        for (int i = 0; i < 6; i++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            do_req(b, k, 2'(i % 2));
            check("rnd_sd_data", resp_data, (i % 2 == 1) ? dec(b, k) : enc(b, k));
            check("rnd_sd_flags", {resp_match, resp_err}, 128'd0);
            ack_resp("rnd_sd");
        end

        // round trip where the core's decrypt is wrong
        stub_fn = 2;
        for (int i = 0; i < 3; i++) begin
            b = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            do_req(b, k, 2'd2);
            check("bad_rt_data", resp_data, enc(b, k));
            check("bad_rt_match", {resp_match, resp_err}, 128'd0);
            ack_resp("bad_rt");
        end

        // reset in the middle of WAIT_LO
        stub_fn = 0;
        @(negedge clk);
        req_block = {4{32'h7777_1111}}; req_key = 128'd3; req_mode = 2'd0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_core_reset", 128'(core_reset), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_idle", {resp_valid, resp_match, resp_err, core_start, core_ende, core_reset,
                           req_ready}, 128'd1);
        check("mid_core_blk", core_block | core_key | resp_data, 128'd0);
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid) stray++;
        end
        check("mid_no_resp", 128'(stray), 128'd0);
        b = {4{32'h2468_ACE0}};
        k = {4{32'h1357_9BDF}};
        do_req(b, k, 2'd0);
        check("post_rst_data", resp_data, b ^ k);
        check("post_rst_t_valid", 128'(t_valid), 128'd25);
        ack_resp("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
